// File: rtl/prbs_checker_pkg.sv
// Shared PRBS definitions: checker state encoding, default seed and the
// 16-bit model register update used by both the generator and the checker.
package prbs_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_LOST
  } state_e;

  localparam logic [15:0] DefaultSeed = 16'hF733;

  // Four new bits enter at the top while the register shifts down by four.
  function automatic logic [15:0] lfsr_next(input logic [15:0] m);
    return {m[8] ^ m[6] ^ m[5] ^ m[3],
            m[7] ^ m[5] ^ m[4] ^ m[2],
            m[6] ^ m[4] ^ m[3] ^ m[1],
            m[5] ^ m[3] ^ m[2] ^ m[0],
            m[15:4]};
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// PRBS checker: compares a qualified received bit stream against a local
// model, counts bits and errors, and drops to a lost state on long error runs.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter logic [15:0] SEED        = DefaultSeed,
  parameter int unsigned LOST_THRESH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_valid,
  input  logic        i_bit,
  output logic        o_locked,
  output logic        o_lost,
  output logic        o_err,
  output logic [15:0] o_bit_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int unsigned    CW       = $clog2(LOST_THRESH + 1);
  localparam logic [CW-1:0]  ConsecMax = CW'(LOST_THRESH);
  localparam logic [CW-1:0]  ConsecEnd = CW'(LOST_THRESH - 1);

  state_e         state_q, state_d;
  logic [15:0]    m_q, m_d;
  logic [15:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [CW-1:0]  consec_q, consec_d;
  logic           err_q, err_d;
  logic           locked_q, lost_q;
  logic           check_en, mismatch;

  // A start or stop in the same cycle as a valid bit suppresses the check.
  assign check_en = (state_q == S_CHECK) && i_valid && !i_start && !i_stop;
  assign mismatch = i_bit != m_q[0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (i_start) begin
          state_d = S_CHECK;
        end else if (i_stop) begin
          state_d = S_IDLE;
        end else if (check_en && mismatch && consec_q >= ConsecEnd) begin
          state_d = S_LOST;
        end
      end
      S_LOST: begin
        if (i_start) begin
          state_d = S_CHECK;
        end else if (i_stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_d       = m_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    consec_d  = consec_q;
    err_d     = 1'b0;
    if (i_start) begin
      m_d       = SEED;
      bit_cnt_d = '0;
      err_cnt_d = '0;
      consec_d  = '0;
    end else if (check_en) begin
      m_d = lfsr_next(m_q);
      if (bit_cnt_q != 16'hFFFF) bit_cnt_d = bit_cnt_q + 16'd1;
      if (mismatch) begin
        err_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (consec_q != ConsecMax) consec_d = consec_q + CW'(1);
      end else begin
        consec_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d == S_CHECK);
      lost_q   <= (state_d == S_LOST);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_q       <= SEED;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      consec_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      m_q       <= m_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      consec_q  <= consec_d;
      err_q     <= err_d;
    end
  end

  assign o_locked  = locked_q;
  assign o_lost    = lost_q;
  assign o_err     = err_q;
  assign o_bit_cnt = bit_cnt_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter SEED, default 16'hF733, initial LFSR model value loaded on every start.
REQ-002 Parameter LOST_THRESH, default 8, consecutive-mismatch count that declares loss of sync.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_start  input  1  one-cycle pulse; reload model with SEED, clear counters, enter S_CHECK.
REQ-006 i_stop  input  1  one-cycle pulse; return to S_IDLE, counters hold.
REQ-007 i_valid  input  1  qualifies i_bit; one received bit per asserted cycle.
REQ-008 i_bit  input  1  received random bit under test.
REQ-009 o_locked  output  1  high while in S_CHECK.
REQ-010 o_lost  output  1  high while in S_LOST.
REQ-011 o_err  output  1  registered one-cycle pulse per mismatching bit.
REQ-012 o_bit_cnt  output  16  bits checked since start, saturating at 16'hFFFF.
REQ-013 o_err_cnt  output  16  mismatches since start, saturating at 16'hFFFF.

Function
REQ-014 Model register m[15:0] SHALL advance per checked bit: m <= {m8^m6^m5^m3, m7^m5^m4^m2, m6^m4^m3^m1, m5^m3^m2^m0, m[15:4]}.
REQ-015 Expected bit SHALL be m[0] before the advance; checked bit k compares i_bit against m[0] of the k-th model state.
REQ-016 FSM states SHALL be S_IDLE, S_CHECK, S_LOST; S_IDLE on reset.
REQ-017 S_IDLE: i_valid ignored, model frozen; i_start -> S_CHECK.
REQ-018 S_CHECK: on i_valid, compare, advance model, increment o_bit_cnt; mismatch increments o_err_cnt and consecutive-mismatch counter, match clears it.
REQ-019 S_CHECK -> S_LOST in the cycle the consecutive-mismatch counter reaches LOST_THRESH; that bit is still counted.
REQ-020 S_LOST: i_valid ignored, model and counters frozen; only i_start or i_stop leave it.
REQ-021 o_err SHALL assert the cycle after the mismatching i_valid (latency 1); no pulse in S_IDLE/S_LOST.
REQ-022 Counters SHALL saturate, never wrap; consecutive-mismatch counter is LOST_THRESH-sized and saturates.
REQ-023 i_start and i_stop in same cycle: i_start wins.
REQ-024 i_start with i_valid in same cycle: that bit is not checked; first check is the next valid cycle against SEED[0].
REQ-025 i_stop with i_valid in S_CHECK: bit not checked.

Reset
REQ-026 i_rst high SHALL immediately force S_IDLE, m=SEED, all counters 0, o_locked=0, o_lost=0, o_err=0, regardless of clock.
REQ-027 Reset asserted mid-check SHALL discard the run; a fresh i_start is required after release.

Structure
REQ-028 Shared package SHALL hold the state enum (S_IDLE, S_CHECK, S_LOST), default SEED constant, and an lfsr_next function implementing REQ-014, shared with the generator.
REQ-029 Single module, no sub-modules; FSM, model, counters in separate combinational/sequential processes.

Verification
REQ-030 Reset, i_start, feed bits 1,1,1,1,0 (model states F733,0F73,A0F7,3A0F,D3A0) -> o_bit_cnt=5, o_err_cnt=0, o_err never high, o_locked=1.
REQ-031 Same stream with third bit inverted -> single o_err pulse one cycle after it, o_err_cnt=1, remains S_CHECK.
REQ-032 After start, 8 consecutive inverted bits -> o_lost=1 after 8th, o_err_cnt=8, further i_valid leaves counters unchanged.
REQ-033 In S_LOST pulse i_start -> S_CHECK, counters 0, correct stream from SEED gives zero errors.
REQ-034 Force o_bit_cnt near 16'hFFFF via long correct stream -> holds at 16'hFFFF, no wrap.
REQ-035 Assert i_rst asynchronously mid-stream (between edges) -> outputs 0 and S_IDLE immediately; i_valid ignored until i_start.
